// File: rtl/zmips_mem_pkg.sv
// Shared constants for the ZMIPS wait-state memory: port FSM encoding,
// wait-counter width and address lane-bit helper.
package zmips_mem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int CNT_W = 4;

    // Number of low byte-address bits that select a lane within one word.
    function automatic int lane_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/zmips_mem_port_fsm.sv
// One memory port: request latch, wait counter, alignment/range check and
// ready/err generation; raises an access strobe on the edge the access happens.
module zmips_mem_port_fsm
    import zmips_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4096,
    parameter int WAIT   = 0,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [IDX_W-1:0]    idx_q,
    output logic [DATA_W-1:0]   wdata_q,
    output logic [DATA_W/8-1:0] be_q,
    output logic                acc_rd,
    output logic                acc_wr,
    output logic                ready,
    output logic                err
);

    localparam int LB = lane_bits(DATA_W);
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'((1 << LB) - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              rd_q;
    logic              wr_q;
    logic              err_q;
    logic [ADDR_W-1:0] widx;
    logic              req;
    logic              bad;
    logic              fire;

    assign req  = rd | wr;
    assign widx = addr >> LB;
    assign bad  = ((addr & LANE_MASK) != '0) || (widx >= DEPTH_A) || (rd && wr);

    // A failed check still walks through WAIT/RESP, it just never touches memory.
    assign fire   = (state == ST_WAIT) && (cnt == '0) && !err_q;
    assign acc_rd = fire && rd_q;
    assign acc_wr = fire && wr_q;
    assign ready  = (state == ST_RESP);
    assign err    = ready && err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (req) begin
                    state <= ST_WAIT;
                    cnt   <= CNT_W'(WAIT);
                    rd_q  <= rd;
                    wr_q  <= wr;
                    err_q <= bad;
                end
                ST_WAIT: if (cnt == '0) state <= ST_RESP;
                         else           cnt   <= cnt - 1'b1;
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req) begin
            idx_q   <= widx[IDX_W-1:0];
            wdata_q <= wdata;
            be_q    <= be;
        end
    end

endmodule

// File: rtl/zmips_wait_mem.sv
// Dual-port ZMIPS memory: read-only instruction port and read/write data port,
// each with its own wait-state FSM; owns the array, lane writes and read registers.
module zmips_wait_mem
    import zmips_mem_pkg::*;
#(
    parameter int    DATA_W    = 32,
    parameter int    ADDR_W    = 32,
    parameter int    DEPTH     = 4096,
    parameter int    I_WAIT    = 0,
    parameter int    D_WAIT    = 2,
    parameter string INIT_FILE = "asm-output.dat"
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_data,
    output logic                i_ready,
    output logic                i_err,
    input  logic                d_rd,
    input  logic                d_wr,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                d_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  i_idx;
    logic [DATA_W-1:0] i_wdata_q;
    logic [NB-1:0]     i_be_q;
    logic              i_acc_rd;
    logic              i_acc_wr;
    logic [IDX_W-1:0]  d_idx;
    logic [DATA_W-1:0] d_wdata_q;
    logic [NB-1:0]     d_be_q;
    logic              d_acc_rd;
    logic              d_acc_wr;

    zmips_mem_port_fsm #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT(I_WAIT), .IDX_W(IDX_W)
    ) u_i_port (
        .clk(clk), .rst(rst), .rd(i_req), .wr(1'b0), .addr(i_addr),
        .wdata('0), .be('0), .idx_q(i_idx), .wdata_q(i_wdata_q), .be_q(i_be_q),
        .acc_rd(i_acc_rd), .acc_wr(i_acc_wr), .ready(i_ready), .err(i_err)
    );

    zmips_mem_port_fsm #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT(D_WAIT), .IDX_W(IDX_W)
    ) u_d_port (
        .clk(clk), .rst(rst), .rd(d_rd), .wr(d_wr), .addr(d_addr),
        .wdata(d_wdata), .be(d_be), .idx_q(d_idx), .wdata_q(d_wdata_q), .be_q(d_be_q),
        .acc_rd(d_acc_rd), .acc_wr(d_acc_wr), .ready(d_ready), .err(d_err)
    );

    // Instruction port is read-only; its write-side latch outputs go nowhere.
    logic unused_i;
    assign unused_i = ^{i_acc_wr, i_wdata_q, i_be_q};

    always_ff @(posedge clk) begin
        if (d_acc_wr) begin
            for (int l = 0; l < NB; l++) begin
                if (d_be_q[l]) mem[d_idx][l*8 +: 8] <= d_wdata_q[l*8 +: 8];
            end
        end
    end

    // Non-blocking reads see the pre-write word: same-edge collisions are read-first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_data  <= '0;
            d_rdata <= '0;
        end else begin
            if (i_acc_rd) i_data  <= mem[i_idx];
            if (d_acc_rd) d_rdata <= mem[d_idx];
        end
    end

endmodule

// File: tb/tb_zmips_wait_mem.sv
// Directed bench for zmips_wait_mem: latency, lane writes, error cases,
// read-first collision and reset abandoning an in-flight write.
module tb_zmips_wait_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_req, i_ready, i_err;
    logic [31:0] i_addr, i_data;
    logic        d_rd, d_wr, d_ready, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;

    logic        b_i_req, b_i_ready, b_i_err;
    logic [31:0] b_i_addr, b_i_data;
    logic        b_d_rd, b_d_wr, b_d_ready, b_d_err;
    logic [31:0] b_d_addr, b_d_wdata, b_d_rdata;
    logic [3:0]  b_d_be;

    int n_chk = 0;
    int n_err = 0;

    zmips_wait_mem #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(64), .I_WAIT(0), .D_WAIT(2), .INIT_FILE("")
    ) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_ready(i_ready), .i_err(i_err),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err)
    );

    zmips_wait_mem #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(64), .I_WAIT(0), .D_WAIT(0), .INIT_FILE("")
    ) u_col (
        .clk(clk), .rst(rst),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_data(b_i_data), .i_ready(b_i_ready), .i_err(b_i_err),
        .d_rd(b_d_rd), .d_wr(b_d_wr), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_be(b_d_be),
        .d_rdata(b_d_rdata), .d_ready(b_d_ready), .d_err(b_d_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic d_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            output int edges, output logic err, output logic [31:0] rdata);
        logic got;
        @(negedge clk);
        d_rd = rd; d_wr = wr; d_addr = addr; d_wdata = wdata; d_be = be;
        @(posedge clk); #1;
        d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        edges = 1; err = 1'b0; rdata = '0; got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk); #1;
            edges++;
            if (d_ready) begin
                got = 1'b1; err = d_err; rdata = d_rdata;
            end
        end
        if (!got) begin
            n_chk++; n_err++;
            $display("FAIL d_timeout got no d_ready expected d_ready within 20 cycles");
        end
        @(posedge clk);
    endtask

    task automatic i_fetch(input logic [31:0] addr,
                           output int edges, output logic err, output logic [31:0] data);
        logic got;
        @(negedge clk);
        i_req = 1'b1; i_addr = addr;
        @(posedge clk); #1;
        i_req = 1'b0; i_addr = '0;
        edges = 1; err = 1'b0; data = '0; got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk); #1;
            edges++;
            if (i_ready) begin
                got = 1'b1; err = i_err; data = i_data;
            end
        end
        if (!got) begin
            n_chk++; n_err++;
            $display("FAIL i_timeout got no i_ready expected i_ready within 20 cycles");
        end
        @(posedge clk);
    endtask

    // Both ports of the zero-wait instance: accept on one edge, access on the next.
    task automatic b_step(input logic ireq, input logic [31:0] iaddr, input logic dwr,
                          input logic [31:0] daddr, input logic [31:0] wdata,
                          output logic iready, output logic dready, output logic [31:0] idata);
        @(negedge clk);
        b_i_req = ireq; b_i_addr = iaddr;
        b_d_wr = dwr; b_d_addr = daddr; b_d_wdata = wdata; b_d_be = 4'hF;
        @(posedge clk); #1;
        b_i_req = 1'b0; b_d_wr = 1'b0;
        @(posedge clk); #1;
        iready = b_i_ready; dready = b_d_ready; idata = b_i_data;
        @(posedge clk);
    endtask

    int          e;
    logic        er, ir, dr, saw;
    logic [31:0] rdv;

    initial begin
        rst = 1'b1;
        i_req = 0; i_addr = 0; d_rd = 0; d_wr = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        b_i_req = 0; b_i_addr = 0; b_d_rd = 0; b_d_wr = 0; b_d_addr = 0; b_d_wdata = 0; b_d_be = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_i_data", i_data, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_i_ready", {31'b0, i_ready}, 32'h0);
        chk("rst_d_ready", {31'b0, d_ready}, 32'h0);
        chk("rst_i_err", {31'b0, i_err}, 32'h0);
        chk("rst_d_err", {31'b0, d_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        d_access(0, 1, 32'h0C, 32'hDEADBEEF, 4'hF, e, er, rdv);
        chk("wr3_lat", e, 4);
        chk("wr3_err", {31'b0, er}, 32'h0);
        #1 chk("d_ready_pulse", {31'b0, d_ready}, 32'h0);

        i_fetch(32'h0C, e, er, rdv);
        chk("fetch3_lat", e, 2);
        chk("fetch3_data", rdv, 32'hDEADBEEF);
        chk("fetch3_err", {31'b0, er}, 32'h0);
        #1 chk("i_ready_pulse", {31'b0, i_ready}, 32'h0);

        d_access(0, 1, 32'h40, 32'h12345678, 4'hF, e, er, rdv);
        chk("wr40_lat", e, 4);
        d_access(1, 0, 32'h40, 32'h0, 4'h0, e, er, rdv);
        chk("rd40_lat", e, 4);
        chk("rd40_data", rdv, 32'h12345678);
        chk("rd40_err", {31'b0, er}, 32'h0);

        d_access(0, 1, 32'h40, 32'hAABBCCDD, 4'b0101, e, er, rdv);
        chk("lane_wr_err", {31'b0, er}, 32'h0);
        d_access(1, 0, 32'h40, 32'h0, 4'h0, e, er, rdv);
        chk("lane_rd_data", rdv, 32'h12BB56DD);

        d_access(0, 1, 32'h41, 32'hFFFFFFFF, 4'hF, e, er, rdv);
        chk("misal_wr_err", {31'b0, er}, 32'h1);
        d_access(1, 0, 32'h40, 32'h0, 4'h0, e, er, rdv);
        chk("misal_no_wr", rdv, 32'h12BB56DD);

        d_access(1, 0, 32'h0C, 32'h0, 4'h0, e, er, rdv);
        chk("rd3_data", rdv, 32'hDEADBEEF);
        d_access(1, 0, 32'h41, 32'h0, 4'h0, e, er, rdv);
        chk("misal_rd_err", {31'b0, er}, 32'h1);
        chk("misal_rd_hold", d_rdata, 32'hDEADBEEF);

        d_access(0, 1, 32'h00, 32'h11111111, 4'hF, e, er, rdv);
        d_access(0, 1, 32'h100, 32'h99999999, 4'hF, e, er, rdv);
        chk("range_err", {31'b0, er}, 32'h1);
        d_access(1, 0, 32'h00, 32'h0, 4'h0, e, er, rdv);
        chk("range_no_wr", rdv, 32'h11111111);

        d_access(1, 1, 32'h40, 32'h00000000, 4'hF, e, er, rdv);
        chk("rdwr_err", {31'b0, er}, 32'h1);
        d_access(0, 1, 32'h40, 32'h00000000, 4'h0, e, er, rdv);
        chk("be0_lat", e, 4);
        chk("be0_err", {31'b0, er}, 32'h0);
        d_access(1, 0, 32'h40, 32'h0, 4'h0, e, er, rdv);
        chk("rdwr_be0_no_wr", rdv, 32'h12BB56DD);

        b_step(0, 32'h0, 1, 32'h14, 32'h01020304, ir, dr, rdv);
        chk("col_init_dready", {31'b0, dr}, 32'h1);
        b_step(1, 32'h14, 1, 32'h14, 32'hCAFEF00D, ir, dr, rdv);
        chk("col_iready", {31'b0, ir}, 32'h1);
        chk("col_dready", {31'b0, dr}, 32'h1);
        chk("col_old_word", rdv, 32'h01020304);
        b_step(1, 32'h14, 0, 32'h0, 32'h0, ir, dr, rdv);
        chk("col_new_word", rdv, 32'hCAFEF00D);

        // Abandon a write while its wait counter is still running.
        @(negedge clk);
        d_wr = 1'b1; d_addr = 32'h40; d_wdata = 32'h55555555; d_be = 4'hF;
        @(posedge clk); #1;
        d_wr = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_i_data", i_data, 32'h0);
        chk("mid_rst_d_rdata", d_rdata, 32'h0);
        chk("mid_rst_ready", {30'b0, i_ready, d_ready}, 32'h0);
        chk("mid_rst_err", {30'b0, i_err, d_err}, 32'h0);
        saw = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            saw = saw | d_ready;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            saw = saw | d_ready;
        end
        chk("mid_rst_no_ready", {31'b0, saw}, 32'h0);
        d_access(1, 0, 32'h40, 32'h0, 4'h0, e, er, rdv);
        chk("mid_rst_no_wr", rdv, 32'h12BB56DD);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
